control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Ports: in_clk  in  1  sole clock; all state changes on rising edge.
REQ-002 Ports: in_reset  in  1  synchronous, active-high reset.
REQ-003 Ports: in_ir  in  32  instruction register contents; [31:27] opcode.
REQ-004 Ports: in_mem_done  in  1  memory handshake; high = current read/write has completed this cycle.
REQ-005 Ports: out_gra, out_grb, out_grc  out  1 each  register-field selects to select/encode stage.
REQ-006 Ports: out_read, out_write, out_base_addr_read  out  1 each  regfile bus-drive, regfile load, base-address read (R0 reads as zero).
REQ-007 Ports: out_pc_out, out_pc_in, out_inc_pc, out_mar_in, out_mdr_in, out_mdr_out, out_ir_in, out_y_in, out_z_in, out_z_lo_out, out_c_out  out  1 each  datapath register strobes.
REQ-008 Ports: out_mem_read, out_mem_write  out  1 each  memory request, held until in_mem_done.
REQ-009 Ports: out_alu_op  out  5  ALU operation code; out_run  out  1  high unless halted.

Function
REQ-010 Sequencer SHALL hold a state register over {T0..T7, HALT}; all outputs SHALL be combinational from state and in_ir[31:27] only (Moore w.r.t. in_mem_done).
REQ-011 Unlisted strobes SHALL be 0 in every state; out_alu_op SHALL be 5'b00000 unless stated.
REQ-012 T0: pc_out, mar_in, inc_pc, z_in; -> T1.
REQ-013 T1: z_lo_out, pc_in, mem_read, mdr_in; stays T1 while in_mem_done=0; -> T2 on in_mem_done=1; pc_in asserted only in the first T1 cycle.
REQ-014 T2: mdr_out, ir_in; -> T3; decode uses in_ir from T3 onward.
REQ-015 ALU reg (opcode 00011..01011): T3 grb,read,y_in; T4 grc,read,z_in,alu_op=opcode; T5 z_lo_out,gra,write; -> T0.
REQ-016 ALU imm (01100..01110): T3 grb,read,y_in; T4 c_out,z_in,alu_op=opcode; T5 z_lo_out,gra,write; -> T0.
REQ-017 ld (00000): T3 grb,base_addr_read,y_in; T4 c_out,z_in,alu_op=00011; T5 z_lo_out,mar_in; T6 mem_read,mdr_in, wait on in_mem_done as T1; T7 mdr_out,gra,write; -> T0.
REQ-018 ldi (00001): T3-T4 as ld; T5 z_lo_out,gra,write; -> T0.
REQ-019 st (00010): T3-T5 as ld; T6 gra,read,mdr_in; T7 mem_write, wait on in_mem_done; -> T0.
REQ-020 jr (10011): T3 gra,read,pc_in; -> T0.
REQ-021 jal (10100): T3 pc_out,grb,write (select stage maps grb+jal to R15); T4 gra,read,pc_in; -> T0.
REQ-022 nop (11001) and every unlisted opcode: T3 all strobes 0; -> T0.
REQ-023 halt (11010): T3 -> HALT; HALT all strobes 0, out_run=0, self-loop until reset.
REQ-024 At most one of gra/grb/grc SHALL be high in any state; out_mem_read and out_mem_write SHALL never both be high.
REQ-025 in_mem_done outside T1/T6(ld)/T7(st) SHALL be ignored.

Reset
REQ-026 in_reset=1 at an edge SHALL force state T0 regardless of current state (including mid-wait and HALT); in_reset has priority over all transitions.
REQ-027 During and after reset, in state T0: out_run=1, all other outputs per REQ-012; no regfile write or memory request is issued in the reset cycle's following state.

Verification
REQ-028 Reset then in_ir=add(00011) R1,R2,R3, in_mem_done=1 -> T0..T5 in 6 cycles; T4 out_alu_op=00011, grc=1; T5 gra=1, write=1; back to T0.
REQ-029 ld opcode, in_mem_done low 3 cycles in T6 -> mem_read,mdr_in held 4 cycles; T7 write=1 exactly once.
REQ-030 jal -> T3 pc_out=1, grb=1, write=1; T4 gra=1, read=1, pc_in=1; next cycle T0.
REQ-031 halt -> out_run=0 from cycle after T3, all strobes 0 for 20 cycles; in_reset pulse -> T0, out_run=1.
REQ-032 Reset asserted during st T7 wait -> next state T0, mem_write=0; unlisted opcode 11111 -> T3 idle, then T0.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore control unit stepping T0..T7/HALT and driving datapath
//               strobes from the current step and the decoded opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic        in_clk,
    input  logic        in_reset,
    input  logic [31:0] in_ir,
    input  logic        in_mem_done,
    output logic        out_gra,
    output logic        out_grb,
    output logic        out_grc,
    output logic        out_read,
    output logic        out_write,
    output logic        out_base_addr_read,
    output logic        out_pc_out,
    output logic        out_pc_in,
    output logic        out_inc_pc,
    output logic        out_mar_in,
    output logic        out_mdr_in,
    output logic        out_mdr_out,
    output logic        out_ir_in,
    output logic        out_y_in,
    output logic        out_z_in,
    output logic        out_z_lo_out,
    output logic        out_c_out,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [4:0]  out_alu_op,
    output logic        out_run
);

    localparam logic [3:0] C_T0   = 4'd0;
    localparam logic [3:0] C_T1   = 4'd1;
    localparam logic [3:0] C_T2   = 4'd2;
    localparam logic [3:0] C_T3   = 4'd3;
    localparam logic [3:0] C_T4   = 4'd4;
    localparam logic [3:0] C_T5   = 4'd5;
    localparam logic [3:0] C_T6   = 4'd6;
    localparam logic [3:0] C_T7   = 4'd7;
    localparam logic [3:0] C_HALT = 4'd8;

    localparam logic [4:0] C_OP_ADD = 5'b00011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_t1_waited;
    logic [4:0] w_op;
    logic       w_alu_r, w_alu_i, w_ld, w_ldi, w_st, w_jr, w_jal, w_halt, w_mem;
    logic       w_unused_ir;

    assign w_op        = in_ir[31:27];
    assign w_unused_ir = ^in_ir[26:0];

    assign w_alu_r = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_alu_i = (w_op >= 5'd12) && (w_op <= 5'd14);
    assign w_ld    = (w_op == 5'b00000);
    assign w_ldi   = (w_op == 5'b00001);
    assign w_st    = (w_op == 5'b00010);
    assign w_jr    = (w_op == 5'b10011);
    assign w_jal   = (w_op == 5'b10100);
    assign w_halt  = (w_op == 5'b11010);
    assign w_mem   = w_ld | w_ldi | w_st;

    // r_t1_waited suppresses pc_in after the first cycle of a stalled fetch
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state     <= C_T0;
            r_t1_waited <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_t1_waited <= (r_state == C_T1) && !in_mem_done;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_T0: w_next = C_T1;
            C_T1: w_next = in_mem_done ? C_T2 : C_T1;
            C_T2: w_next = C_T3;
            C_T3: begin
                if (w_halt)
                    w_next = C_HALT;
                else if (w_alu_r || w_alu_i || w_mem || w_jal)
                    w_next = C_T4;
                else
                    w_next = C_T0;
            end
            C_T4: w_next = w_jal ? C_T0 : C_T5;
            C_T5: w_next = (w_ld || w_st) ? C_T6 : C_T0;
            C_T6: begin
                if (w_ld)
                    w_next = in_mem_done ? C_T7 : C_T6;
                else if (w_st)
                    w_next = C_T7;
                else
                    w_next = C_T0;
            end
            C_T7: w_next = (w_st && !in_mem_done) ? C_T7 : C_T0;
            C_HALT: w_next = C_HALT;
            default: w_next = C_T0;
        endcase
    end

    always_comb begin
        out_gra            = 1'b0;
        out_grb            = 1'b0;
        out_grc            = 1'b0;
        out_read           = 1'b0;
        out_write          = 1'b0;
        out_base_addr_read = 1'b0;
        out_pc_out         = 1'b0;
        out_pc_in          = 1'b0;
        out_inc_pc         = 1'b0;
        out_mar_in         = 1'b0;
        out_mdr_in         = 1'b0;
        out_mdr_out        = 1'b0;
        out_ir_in          = 1'b0;
        out_y_in           = 1'b0;
        out_z_in           = 1'b0;
        out_z_lo_out       = 1'b0;
        out_c_out          = 1'b0;
        out_mem_read       = 1'b0;
        out_mem_write      = 1'b0;
        out_alu_op         = 5'b00000;
        out_run            = (r_state != C_HALT);
        case (r_state)
            C_T0: begin
                out_pc_out = 1'b1;
                out_mar_in = 1'b1;
                out_inc_pc = 1'b1;
                out_z_in   = 1'b1;
            end
            C_T1: begin
                out_z_lo_out = 1'b1;
                out_pc_in    = !r_t1_waited;
                out_mem_read = 1'b1;
                out_mdr_in   = 1'b1;
            end
            C_T2: begin
                out_mdr_out = 1'b1;
                out_ir_in   = 1'b1;
            end
            C_T3: begin
                if (w_alu_r || w_alu_i) begin
                    out_grb  = 1'b1;
                    out_read = 1'b1;
                    out_y_in = 1'b1;
                end else if (w_mem) begin
                    out_grb            = 1'b1;
                    out_base_addr_read = 1'b1;
                    out_y_in           = 1'b1;
                end else if (w_jr) begin
                    out_gra   = 1'b1;
                    out_read  = 1'b1;
                    out_pc_in = 1'b1;
                end else if (w_jal) begin
                    // select stage maps grb together with jal onto R15
                    out_pc_out = 1'b1;
                    out_grb    = 1'b1;
                    out_write  = 1'b1;
                end
            end
            C_T4: begin
                if (w_alu_r) begin
                    out_grc    = 1'b1;
                    out_read   = 1'b1;
                    out_z_in   = 1'b1;
                    out_alu_op = w_op;
                end else if (w_alu_i) begin
                    out_c_out  = 1'b1;
                    out_z_in   = 1'b1;
                    out_alu_op = w_op;
                end else if (w_mem) begin
                    out_c_out  = 1'b1;
                    out_z_in   = 1'b1;
                    out_alu_op = C_OP_ADD;
                end else if (w_jal) begin
                    out_gra   = 1'b1;
                    out_read  = 1'b1;
                    out_pc_in = 1'b1;
                end
            end
            C_T5: begin
                if (w_alu_r || w_alu_i || w_ldi) begin
                    out_z_lo_out = 1'b1;
                    out_gra      = 1'b1;
                    out_write    = 1'b1;
                end else if (w_ld || w_st) begin
                    out_z_lo_out = 1'b1;
                    out_mar_in   = 1'b1;
                end
            end
            C_T6: begin
                if (w_ld) begin
                    out_mem_read = 1'b1;
                    out_mdr_in   = 1'b1;
                end else if (w_st) begin
                    out_gra    = 1'b1;
                    out_read   = 1'b1;
                    out_mdr_in = 1'b1;
                end
            end
            C_T7: begin
                if (w_ld) begin
                    out_mdr_out = 1'b1;
                    out_gra     = 1'b1;
                    out_write   = 1'b1;
                end else if (w_st) begin
                    out_mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed and randomized checks of control_sequencer against a
//               micro-program table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int GRA = 0, GRB = 1, GRC = 2, RD = 3, WR = 4, BASE = 5, PCO = 6;
    localparam int PCI = 7, INC = 8, MARI = 9, MDRI = 10, MDRO = 11, IRI = 12;
    localparam int YI = 13, ZI = 14, ZLO = 15, CO = 16, MRD = 17, MWR = 18;

    typedef struct packed {
        logic [18:0] s;
        logic [4:0]  alu;
        logic        wt;
        logic        hlt;
    } step_t;

    logic        clk;
    logic        in_reset;
    logic [31:0] in_ir;
    logic        in_mem_done;
    logic        gra, grb, grc, rd, wr, base, pc_out, pc_in, inc_pc, mar_in;
    logic        mdr_in, mdr_out, ir_in, y_in, z_in, z_lo_out, c_out;
    logic        mem_read, mem_write, run;
    logic [4:0]  alu_op;
    logic [18:0] dut_s;

    int checks = 0;
    int errors = 0;

    int m_k     = 0;
    bit m_halt  = 1'b0;
    bit m_first = 1'b1;
    bit m_valid = 1'b0;

    control_sequencer dut (
        .in_clk             (clk),
        .in_reset           (in_reset),
        .in_ir              (in_ir),
        .in_mem_done        (in_mem_done),
        .out_gra            (gra),
        .out_grb            (grb),
        .out_grc            (grc),
        .out_read           (rd),
        .out_write          (wr),
        .out_base_addr_read (base),
        .out_pc_out         (pc_out),
        .out_pc_in          (pc_in),
        .out_inc_pc         (inc_pc),
        .out_mar_in         (mar_in),
        .out_mdr_in         (mdr_in),
        .out_mdr_out        (mdr_out),
        .out_ir_in          (ir_in),
        .out_y_in           (y_in),
        .out_z_in           (z_in),
        .out_z_lo_out       (z_lo_out),
        .out_c_out          (c_out),
        .out_mem_read       (mem_read),
        .out_mem_write      (mem_write),
        .out_alu_op         (alu_op),
        .out_run            (run)
    );

    assign dut_s = {mem_write, mem_read, c_out, z_lo_out, z_in, y_in, ir_in, mdr_out,
                    mdr_in, mar_in, inc_pc, pc_in, pc_out, base, wr, rd, grc, grb, gra};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] b(input int idx);
        return 19'(1) << idx;
    endfunction

    function automatic step_t mk(input logic [18:0] s, input logic [4:0] alu,
                                 input logic wt, input logic hlt);
        step_t st;
        st.s = s; st.alu = alu; st.wt = wt; st.hlt = hlt;
        return st;
    endfunction

    function automatic int prog_len(input logic [4:0] op);
        if ((op >= 5'd3 && op <= 5'd14) || op == 5'd1) return 6;
        if (op == 5'd0 || op == 5'd2) return 8;
        if (op == 5'd20) return 5;
        return 4;
    endfunction

    // Whole micro-program of one instruction as a list of steps
    function automatic step_t prog_step(input logic [4:0] op, input int k);
        step_t p [8];
        for (int i = 0; i < 8; i++) p[i] = mk('0, '0, 1'b0, 1'b0);
        p[0] = mk(b(PCO) | b(MARI) | b(INC) | b(ZI), '0, 1'b0, 1'b0);
        p[1] = mk(b(ZLO) | b(PCI) | b(MRD) | b(MDRI), '0, 1'b1, 1'b0);
        p[2] = mk(b(MDRO) | b(IRI), '0, 1'b0, 1'b0);
        if (op >= 5'd3 && op <= 5'd14) begin
            p[3] = mk(b(GRB) | b(RD) | b(YI), '0, 1'b0, 1'b0);
            p[4] = (op <= 5'd11) ? mk(b(GRC) | b(RD) | b(ZI), op, 1'b0, 1'b0)
                                 : mk(b(CO) | b(ZI), op, 1'b0, 1'b0);
            p[5] = mk(b(ZLO) | b(GRA) | b(WR), '0, 1'b0, 1'b0);
        end else if (op <= 5'd2) begin
            p[3] = mk(b(GRB) | b(BASE) | b(YI), '0, 1'b0, 1'b0);
            p[4] = mk(b(CO) | b(ZI), 5'd3, 1'b0, 1'b0);
            p[5] = (op == 5'd1) ? mk(b(ZLO) | b(GRA) | b(WR), '0, 1'b0, 1'b0)
                                : mk(b(ZLO) | b(MARI), '0, 1'b0, 1'b0);
            if (op == 5'd0) begin
                p[6] = mk(b(MRD) | b(MDRI), '0, 1'b1, 1'b0);
                p[7] = mk(b(MDRO) | b(GRA) | b(WR), '0, 1'b0, 1'b0);
            end else begin
                p[6] = mk(b(GRA) | b(RD) | b(MDRI), '0, 1'b0, 1'b0);
                p[7] = mk(b(MWR), '0, 1'b1, 1'b0);
            end
        end else if (op == 5'd19) begin
            p[3] = mk(b(GRA) | b(RD) | b(PCI), '0, 1'b0, 1'b0);
        end else if (op == 5'd20) begin
            p[3] = mk(b(PCO) | b(GRB) | b(WR), '0, 1'b0, 1'b0);
            p[4] = mk(b(GRA) | b(RD) | b(PCI), '0, 1'b0, 1'b0);
        end else if (op == 5'd26) begin
            p[3] = mk('0, '0, 1'b0, 1'b1);
        end
        return p[k];
    endfunction

    task automatic model_update();
        step_t st;
        if (in_reset) begin
            m_k = 0; m_halt = 1'b0; m_first = 1'b1; m_valid = 1'b1;
        end else if (m_valid && !m_halt) begin
            st = prog_step(in_ir[31:27], m_k);
            if (st.wt && !in_mem_done) begin
                m_first = 1'b0;
            end else if (st.hlt) begin
                m_halt = 1'b1;
            end else begin
                m_k = m_k + 1;
                if (m_k >= prog_len(in_ir[31:27])) m_k = 0;
                m_first = 1'b1;
            end
        end
    endtask

    task automatic model_compare();
        step_t       st;
        logic [18:0] exp_s;
        logic [4:0]  exp_alu;
        logic        exp_run;
        if (!m_valid) return;
        if (m_halt) begin
            exp_s = '0; exp_alu = '0; exp_run = 1'b0;
        end else begin
            st = prog_step(in_ir[31:27], m_k);
            exp_s = st.s;
            if (st.wt && !m_first) exp_s[PCI] = 1'b0;
            exp_alu = st.alu;
            exp_run = 1'b1;
        end
        checks++;
        if (dut_s !== exp_s || alu_op !== exp_alu || run !== exp_run) begin
            errors++;
            $display("FAIL model t=%0t step=%0d op=%0d: strobes=%b alu=%0d run=%b, expected strobes=%b alu=%0d run=%b",
                     $time, m_k, in_ir[31:27], dut_s, alu_op, run, exp_s, exp_alu, exp_run);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_compare();
        #1;
    endtask

    task automatic go(input int n);
        repeat (n) cyc();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr(input logic [4:0] op);
        return {op, 27'($urandom)};
    endfunction

    logic [4:0] ops [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 5'd11, 5'd12, 5'd14,
                             5'd19, 5'd20, 5'd25, 5'd26, 5'd31, 5'd15};

    initial begin
        int cnt;
        in_reset = 1'b1; in_ir = '0; in_mem_done = 1'b0;
        go(2);
        chk("reset_run", int'(run), 1);
        chk("reset_pc_out", int'(pc_out), 1);
        chk("reset_no_mem", int'(mem_read | mem_write | wr), 0);

        // add R1,R2,R3
        in_reset = 1'b0; in_mem_done = 1'b1;
        in_ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        cyc(); chk("add_t1_pc_in", int'(pc_in & mem_read), 1);
        go(2); chk("add_t3_grb_y", int'(grb & rd & y_in), 1);
        cyc(); chk("add_t4_alu", int'(alu_op), 3);
        chk("add_t4_grc", int'(grc), 1);
        cyc(); chk("add_t5_write", int'(gra & wr), 1);
        cyc(); chk("add_back_t0", int'(pc_out & inc_pc), 1);

        // ld with 3 stalled cycles in T6
        in_ir = instr(5'd0);
        go(5); in_mem_done = 1'b0;
        cyc();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_read && mdr_in) cnt++;
            if (i == 3) in_mem_done = 1'b1;
            cyc();
        end
        chk("ld_mem_read_cycles", cnt, 4);
        chk("ld_t7_write", int'(wr & gra & mdr_out), 1);
        cyc(); chk("ld_t0_no_write", int'(wr), 0);

        // jal
        in_ir = instr(5'd20);
        go(3); chk("jal_t3", int'(pc_out & grb & wr), 1);
        cyc(); chk("jal_t4", int'(gra & rd & pc_in), 1);
        cyc(); chk("jal_t0", int'(pc_out & mar_in), 1);

        // halt, then reset release
        in_ir = instr(5'd26);
        go(3); chk("halt_t3_run", int'(run), 1);
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk("halt_idle", int'({run, dut_s, alu_op}), 0);
            in_mem_done = 1'($urandom);
            cyc();
        end
        in_reset = 1'b1; cyc(); in_reset = 1'b0;
        chk("halt_reset_run", int'(run), 1);
        chk("halt_reset_pc_out", int'(pc_out), 1);

        // st, reset during T7 wait
        in_ir = instr(5'd2); in_mem_done = 1'b1;
        go(5); in_mem_done = 1'b0;
        go(2); chk("st_t7_write", int'(mem_write), 1);
        cyc(); chk("st_t7_hold", int'(mem_write & ~mem_read), 1);
        in_reset = 1'b1; cyc(); in_reset = 1'b0;
        chk("st_reset_mem_write", int'(mem_write), 0);
        chk("st_reset_t0", int'(pc_out), 1);

        // unlisted opcode
        in_ir = instr(5'd31); in_mem_done = 1'b1;
        go(3); chk("op31_idle", int'({dut_s, alu_op}), 0);
        cyc(); chk("op31_t0", int'(pc_out), 1);

        // randomized run; instruction changes only at instruction boundaries
        for (int i = 0; i < 4000; i++) begin
            in_reset    = ($urandom_range(0, 99) == 0);
            in_mem_done = ($urandom_range(0, 9) < 6);
            if (m_k == 0 && !m_halt) in_ir = instr(ops[$urandom_range(0, 13)]);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
